// File: rtl/fetch_redirect_unit_pkg.sv
// rtl/fetch_redirect_unit_pkg.sv - shared types and constants for the instruction fetch front end
package fetch_redirect_unit_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RSP,
        DISCARD
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous buffer of fetched {pc, instr} entries; clear beats push
module fetch_fifo
    import fetch_redirect_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  fetch_entry_t             data_i,
    input  logic                     pop_i,
    output fetch_entry_t             data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rptr;
    logic [AW-1:0] wptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count == (AW+1)'(DEPTH));
    assign empty_o = (count == '0);
    assign do_pop  = pop_i && !empty_o;
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (clear_i) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) mem[wptr] <= data_i;
    end

    assign data_o  = mem[rptr];
    assign count_o = count;

endmodule

// File: rtl/fetch_redirect_unit.sv
// rtl/fetch_redirect_unit.sv - PC generation, imem request sequencing and flush redirect
module fetch_redirect_unit
    import fetch_redirect_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    fetch_state_t  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   rpc_q, rpc_d;
    logic          rpend_q, rpend_d;
    logic          push;
    logic          pop;
    logic [31:0]   target;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] cnt_after;
    logic          fifo_full;
    logic          fifo_empty;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;

    assign target        = word_align(redirect_pc_i);
    assign instr_valid_o = !fifo_empty;
    assign pop           = instr_valid_o && instr_ready_i && !flush_i;
    assign cnt_after     = fifo_count + CW'(1) - CW'(pop);
    assign push_entry    = '{pc: pc_q, instr: imem_rdata_i};

    // pc_q is the address of the request in flight (or the next one when idle);
    // a flush seen while a request waits for grant is parked in rpc_q.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        rpc_d   = rpc_q;
        rpend_d = rpend_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (flush_i) begin
                    pc_d    = target;
                    state_d = REQ;
                end else if (!fifo_full) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (imem_gnt_i) begin
                    rpend_d = 1'b0;
                    if (flush_i) begin
                        pc_d    = target;
                        state_d = DISCARD;
                    end else if (rpend_q) begin
                        pc_d    = rpc_q;
                        state_d = DISCARD;
                    end else begin
                        state_d = WAIT_RSP;
                    end
                end else if (flush_i) begin
                    rpend_d = 1'b1;
                    rpc_d   = target;
                end
            end
            WAIT_RSP: begin
                if (flush_i) begin
                    pc_d    = target;
                    state_d = imem_rvalid_i ? REQ : DISCARD;
                end else if (imem_rvalid_i) begin
                    push    = 1'b1;
                    pc_d    = pc_q + 32'd4;
                    state_d = (cnt_after < DEPTH_C) ? REQ : IDLE;
                end
            end
            DISCARD: begin
                if (flush_i) pc_d = target;
                if (imem_rvalid_i) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            rpc_q   <= '0;
            rpend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            rpc_q   <= rpc_d;
            rpend_q <= rpend_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (flush_i),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign imem_req_o  = (state_q == REQ);
    assign imem_addr_o = pc_q;
    assign instr_o     = instr_valid_o ? head.instr : NOP_INSTR;
    assign instr_pc_o  = instr_valid_o ? head.pc : 32'h0;

endmodule
